// File: rtl/alu_seq_pkg.sv
// Shared opcodes, state encoding and sizing for the ALU sequencer.
// Optional build macro ALU_SEQ_PERF_EN adds performance counters.
package alu_seq_pkg;

  localparam int N_DEF  = 4;
  localparam int ITER_W = $clog2(N_DEF + 1);

  localparam logic [2:0] OPC_ADD = 3'd0;
  localparam logic [2:0] OPC_SUB = 3'd1;
  localparam logic [2:0] OPC_AND = 3'd2;
  localparam logic [2:0] OPC_MUL = 3'd3;
  localparam logic [2:0] OPC_DIV = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_MUL_ADD,
    S_MUL_SHR,
    S_DIV_SHL,
    S_DIV_SUB,
    S_DIV_RST,
    S_DONE
  } state_t;

  // An operation ends in error for unknown opcodes or a divide by zero.
  function automatic logic opc_is_err(input logic [2:0] opc, input logic bz);
    return (opc > OPC_DIV) || ((opc == OPC_DIV) && bz);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Decode/datapath <-> sequencer signal bundle. ALU_SEQ_PERF_EN adds the
// perf_cycles/op_count outputs.
interface alu_seq_ctrl_if;

  logic       start;
  logic [2:0] opcode;
  logic       b_zero;
  logic       alu_lsb;
  logic       acc_msb;
  logic       cout;
  logic       busy;
  logic       done;
  logic       err;
  logic       acc_init;
  logic       breg_load;
  logic       op_add;
  logic       op_sub;
  logic       op_mul;
  logic       op_div;
  logic       op_and;
  logic       acc_load_high;
  logic       acc_shr;
  logic       acc_shl;
  logic       acc_set_lsb;
`ifdef ALU_SEQ_PERF_EN
  logic [7:0] perf_cycles;
  logic [7:0] op_count;
`endif

  modport slave (
    input  start, opcode, b_zero, alu_lsb, acc_msb, cout,
`ifdef ALU_SEQ_PERF_EN
    output perf_cycles, op_count,
`endif
    output busy, done, err, acc_init, breg_load,
    output op_add, op_sub, op_mul, op_div, op_and,
    output acc_load_high, acc_shr, acc_shl, acc_set_lsb
  );

  modport master (
    output start, opcode, b_zero, alu_lsb, acc_msb, cout,
`ifdef ALU_SEQ_PERF_EN
    input  perf_cycles, op_count,
`endif
    input  busy, done, err, acc_init, breg_load,
    input  op_add, op_sub, op_mul, op_div, op_and,
    input  acc_load_high, acc_shr, acc_shl, acc_set_lsb
  );

endinterface

// File: rtl/alu_seq_iter_cnt.sv
// Iteration counter for MUL/DIV loops; last flags the final iteration and
// the count wraps to 0 as that iteration exits.
module alu_seq_iter_cnt
  import alu_seq_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = ITER_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [W-1:0] count_reg;

  assign last = (count_reg == W'(N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= last ? '0 : count_reg + W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer FSM: single-step ADD/SUB/AND, shift-add MUL, restoring DIV.
// Build with ALU_SEQ_PERF_EN to add perf_cycles and op_count.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_seq_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] opc_reg;
  logic       b_zero_reg;
  logic       msb_q_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       err_reg;
  logic       acc_init_reg;
  logic       breg_load_reg;
  logic       op_add_reg;
  logic       op_sub_reg;
  logic       op_mul_reg;
  logic       op_div_reg;
  logic       op_and_reg;
  logic       load_high_reg;
  logic       acc_shr_reg;
  logic       acc_shl_reg;
  logic       sub_ok;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_last;
  logic       accept;

  assign accept  = (state_reg == S_IDLE) && bus.start;
  // Shifted-out MSB means the partial remainder is >= 2^N, so the subtract always fits.
  assign sub_ok  = bus.cout | msb_q_reg;
  assign cnt_clr = (state_reg == S_LOAD);
  assign cnt_inc = (state_reg == S_MUL_SHR) || (state_reg == S_DIV_RST) ||
                   ((state_reg == S_DIV_SUB) && sub_ok);

  alu_seq_iter_cnt #(
    .N (N),
    .W (CNT_W)
  ) u_iter_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .last    (cnt_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (bus.start) state_next = S_LOAD;
      S_LOAD: begin
        if (opc_is_err(opc_reg, b_zero_reg)) state_next = S_DONE;
        else if (opc_reg == OPC_MUL)         state_next = S_MUL_ADD;
        else if (opc_reg == OPC_DIV)         state_next = S_DIV_SHL;
        else                                 state_next = S_EXEC;
      end
      S_EXEC:    state_next = S_DONE;
      S_MUL_ADD: state_next = S_MUL_SHR;
      S_MUL_SHR: state_next = cnt_last ? S_DONE : S_MUL_ADD;
      S_DIV_SHL: state_next = S_DIV_SUB;
      S_DIV_SUB: begin
        if (!sub_ok)       state_next = S_DIV_RST;
        else if (cnt_last) state_next = S_DONE;
        else               state_next = S_DIV_SHL;
      end
      S_DIV_RST: state_next = cnt_last ? S_DONE : S_DIV_SHL;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      opc_reg       <= '0;
      b_zero_reg    <= 1'b0;
      msb_q_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      acc_init_reg  <= 1'b0;
      breg_load_reg <= 1'b0;
      op_add_reg    <= 1'b0;
      op_sub_reg    <= 1'b0;
      op_mul_reg    <= 1'b0;
      op_div_reg    <= 1'b0;
      op_and_reg    <= 1'b0;
      load_high_reg <= 1'b0;
      acc_shr_reg   <= 1'b0;
      acc_shl_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        opc_reg    <= bus.opcode;
        b_zero_reg <= bus.b_zero;
      end
      if (state_reg == S_DIV_SHL) msb_q_reg <= bus.acc_msb;
      busy_reg      <= (state_next != S_IDLE);
      done_reg      <= (state_next == S_DONE);
      err_reg       <= (state_next == S_DONE) && opc_is_err(opc_reg, b_zero_reg);
      acc_init_reg  <= (state_next == S_LOAD);
      breg_load_reg <= (state_next == S_LOAD);
      op_add_reg    <= ((state_next == S_EXEC) && (opc_reg == OPC_ADD)) ||
                       (state_next == S_DIV_RST);
      op_sub_reg    <= (state_next == S_EXEC) && (opc_reg == OPC_SUB);
      op_and_reg    <= (state_next == S_EXEC) && (opc_reg == OPC_AND);
      op_mul_reg    <= (state_next == S_MUL_ADD);
      op_div_reg    <= (state_next == S_DIV_SUB);
      load_high_reg <= (state_next == S_EXEC) || (state_next == S_DIV_SUB) ||
                       (state_next == S_DIV_RST);
      acc_shr_reg   <= (state_next == S_MUL_SHR);
      acc_shl_reg   <= (state_next == S_DIV_SHL);
    end
  end

  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.err           = err_reg;
  assign bus.acc_init      = acc_init_reg;
  assign bus.breg_load     = breg_load_reg;
  assign bus.op_add        = op_add_reg;
  assign bus.op_sub        = op_sub_reg;
  assign bus.op_mul        = op_mul_reg;
  assign bus.op_div        = op_div_reg;
  assign bus.op_and        = op_and_reg;
  // ACC[0] and the adder carry are only known within the step that uses them.
  assign bus.acc_load_high = load_high_reg | (op_mul_reg & bus.alu_lsb);
  assign bus.acc_shr       = acc_shr_reg;
  assign bus.acc_shl       = acc_shl_reg;
  assign bus.acc_set_lsb   = op_div_reg & sub_ok;

`ifdef ALU_SEQ_PERF_EN
  logic [7:0] run_cnt_reg;
  logic [7:0] perf_cycles_reg;
  logic [7:0] op_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_reg     <= '0;
      perf_cycles_reg <= '0;
      op_count_reg    <= '0;
    end else begin
      if (accept)        run_cnt_reg <= 8'd1;
      else if (busy_reg) run_cnt_reg <= run_cnt_reg + 8'd1;
      if (state_next == S_DONE) begin
        perf_cycles_reg <= run_cnt_reg + 8'd1;
        op_count_reg    <= op_count_reg + 8'd1;
      end
    end
  end

  assign bus.perf_cycles = perf_cycles_reg;
  assign bus.op_count    = op_count_reg;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural ALU + ACC/BREG datapath;
// results are checked against plain arithmetic on the operands.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl #(.N(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath
  logic [7:0] acc = 8'd0;
  logic [3:0] breg = 4'd0;
  logic       carry_flag = 1'b0;
  logic [7:0] dp_a;
  logic [3:0] dp_b;
  logic [4:0] alu_sum;
  logic [13:0] outs;

  always_comb begin
    alu_sum = {1'b0, acc[7:4]} + {1'b0, breg};
    if (bus.op_sub || bus.op_div) alu_sum = {1'b0, acc[7:4]} + {1'b0, ~breg} + 5'd1;
    else if (bus.op_and)          alu_sum = {1'b0, acc[7:4] & breg};
  end

  assign bus.cout    = alu_sum[4];
  assign bus.alu_lsb = acc[0];
  assign bus.acc_msb = acc[7];
  assign outs = {bus.busy, bus.done, bus.err, bus.acc_init, bus.breg_load, bus.op_add, bus.op_sub,
                 bus.op_mul, bus.op_div, bus.op_and, bus.acc_load_high, bus.acc_shr, bus.acc_shl,
                 bus.acc_set_lsb};

  always @(posedge clk) begin
    if (bus.acc_init)           acc <= dp_a;
    else if (bus.acc_shr)       acc <= {carry_flag, acc[7:1]};
    else if (bus.acc_shl)       acc <= {acc[6:0], 1'b0};
    else if (bus.acc_load_high) acc <= {alu_sum[3:0], acc[3:1], bus.acc_set_lsb ? 1'b1 : acc[0]};
    if (bus.breg_load) breg <= dp_b;
    if (bus.op_mul)    carry_flag <= bus.acc_load_high & alu_sum[4];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one operation and observe it until done (bounded).
  task automatic run_op(input logic [2:0] opc, input logic [7:0] a, input logic [3:0] b,
                        input logic bz, output int lat, output logic err_o,
                        output int strobe_cyc, output logic div_seen, output logic err_early);
    logic fin;
    lat = 0; err_o = 1'b0; strobe_cyc = 0; div_seen = 1'b0; err_early = 1'b0; fin = 1'b0;
    @(negedge clk);
    dp_a = a; dp_b = b;
    bus.opcode = opc; bus.b_zero = bz; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (!fin) begin
        @(negedge clk);
        if (bus.op_div) div_seen = 1'b1;
        if ((bus.op_add || bus.op_sub || bus.op_and) && bus.acc_load_high && strobe_cyc == 0)
          strobe_cyc = k;
        if (bus.err && !bus.done) err_early = 1'b1;
        if (bus.done) begin
          lat = k; err_o = bus.err; fin = 1'b1;
        end
      end
    end
    $display("op=%0d a=%0d b=%0d bz=%0d lat=%0d err=%0d acc=%0d", opc, a, b, bz, lat, err_o, acc);
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.opcode = 3'd0; bus.b_zero = 1'b0;
    dp_a = 8'd0; dp_b = 4'd0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (outs !== 14'd0) begin n_fail++; $display("FAIL reset_outs got %b exp 0", outs); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== 14'd0) begin n_fail++; $display("FAIL idle_outs got %b exp 0", outs); end
`ifdef ALU_SEQ_PERF_EN
    n_checks++;
    if (bus.perf_cycles !== 8'd0 || bus.op_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_perf got %0d/%0d exp 0/0", bus.perf_cycles, bus.op_count);
    end
`endif
  endtask

  task automatic test_add_fixed();
    int lat, sc; logic e, dv, ee;
    run_op(3'd0, {4'd9, 4'd6}, 4'd5, 1'b0, lat, e, sc, dv, ee);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL add_lat got %0d exp 3", lat); end
    n_checks++; if (sc !== 2) begin n_fail++; $display("FAIL add_strobe_cyc got %0d exp 2", sc); end
    n_checks++; if (acc !== {4'd14, 4'd6}) begin n_fail++; $display("FAIL add_acc got %0d exp %0d", acc, {4'd14, 4'd6}); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL add_err got %0d exp 0", e); end
  endtask

  task automatic test_alu_random();
    int lat, sc; logic e, dv, ee;
    logic [2:0] opc; logic [7:0] a; logic [3:0] b; logic [3:0] hi;
    for (int i = 0; i < 10; i++) begin
      opc = 3'($urandom_range(0, 2));
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      if (opc == 3'd0)      hi = 4'((int'(a[7:4]) + int'(b)) % 16);
      else if (opc == 3'd1) hi = 4'((int'(a[7:4]) - int'(b) + 16) % 16);
      else                  hi = a[7:4] & b;
      run_op(opc, a, b, 1'b0, lat, e, sc, dv, ee);
      n_checks++;
      if (acc !== {hi, a[3:0]} || lat !== 3 || e !== 1'b0) begin
        n_fail++; $display("FAIL alu_rand op=%0d acc got %0d exp %0d lat %0d err %0d", opc, acc, {hi, a[3:0]}, lat, e);
      end
    end
  endtask

  task automatic test_mul();
    int lat, sc; logic e, dv, ee;
    logic [3:0] ma [0:8];
    logic [3:0] mb [0:8];
    ma[0] = 4'd13; mb[0] = 4'd11;
    ma[1] = 4'd0;  mb[1] = 4'd15;
    ma[2] = 4'd15; mb[2] = 4'd15;
    for (int i = 3; i < 9; i++) begin
      ma[i] = 4'($urandom_range(0, 15)); mb[i] = 4'($urandom_range(0, 15));
    end
    for (int i = 0; i < 9; i++) begin
      run_op(3'd3, {4'd0, ma[i]}, mb[i], 1'b0, lat, e, sc, dv, ee);
      n_checks++;
      if (acc !== 8'(int'(ma[i]) * int'(mb[i]))) begin
        n_fail++; $display("FAIL mul_acc %0dx%0d got %0d exp %0d", ma[i], mb[i], acc, int'(ma[i]) * int'(mb[i]));
      end
      n_checks++;
      if (lat !== 10 || e !== 1'b0) begin
        n_fail++; $display("FAIL mul_lat %0dx%0d got lat %0d err %0d exp 10/0", ma[i], mb[i], lat, e);
      end
    end
  endtask

  task automatic test_div();
    int lat, sc; logic e, dv, ee;
    int q, r, exp_lat;
    logic [7:0] dd [0:10];
    logic [3:0] dv_b [0:10];
    dd[0] = 8'd100; dv_b[0] = 4'd7;
    dd[1] = 8'd120; dv_b[1] = 4'd9;
    dd[2] = 8'd127; dv_b[2] = 4'd8;
    for (int i = 3; i < 11; i++) begin
      dv_b[i] = 4'($urandom_range(1, 15));
      dd[i] = 8'($urandom_range(0, int'(dv_b[i]) * 16 - 1));
    end
    for (int i = 0; i < 11; i++) begin
      q = int'(dd[i]) / int'(dv_b[i]);
      r = int'(dd[i]) % int'(dv_b[i]);
      exp_lat = 10 + 4 - $countones(4'(q));
      run_op(3'd4, dd[i], dv_b[i], 1'b0, lat, e, sc, dv, ee);
      n_checks++;
      if (acc !== {4'(r), 4'(q)}) begin
        n_fail++; $display("FAIL div_acc %0d/%0d got %0d exp %0d", dd[i], dv_b[i], acc, {4'(r), 4'(q)});
      end
      n_checks++;
      if (lat !== exp_lat || e !== 1'b0) begin
        n_fail++; $display("FAIL div_lat %0d/%0d got lat %0d err %0d exp %0d/0", dd[i], dv_b[i], lat, e, exp_lat);
      end
    end
  endtask

  task automatic test_errors();
    int lat, sc; logic e, dv, ee;
    run_op(3'd4, 8'd100, 4'd0, 1'b1, lat, e, sc, dv, ee);
    n_checks++;
    if (lat !== 2 || e !== 1'b1 || dv !== 1'b0 || ee !== 1'b0) begin
      n_fail++; $display("FAIL div_zero got lat %0d err %0d div %0d early %0d exp 2/1/0/0", lat, e, dv, ee);
    end
    for (int o = 5; o <= 7; o++) begin
      run_op(3'(o), 8'd33, 4'd3, 1'b0, lat, e, sc, dv, ee);
      n_checks++;
      if (lat !== 2 || e !== 1'b1 || sc !== 0 || ee !== 1'b0) begin
        n_fail++; $display("FAIL illegal_op%0d got lat %0d err %0d strobe %0d exp 2/1/0", o, lat, e, sc);
      end
    end
    // b_zero only matters for DIV
    run_op(3'd0, {4'd3, 4'd0}, 4'd0, 1'b1, lat, e, sc, dv, ee);
    n_checks++;
    if (lat !== 3 || e !== 1'b0) begin
      n_fail++; $display("FAIL add_bzero got lat %0d err %0d exp 3/0", lat, e);
    end
  endtask

  task automatic test_start_held();
    int inits, dones, done_at;
    logic fin;
    inits = 0; dones = 0; done_at = 0; fin = 1'b0;
    @(negedge clk);
    dp_a = {4'd0, 4'd13}; dp_b = 4'd11; bus.opcode = 3'd3; bus.b_zero = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.acc_init && k > 1) inits++;
      if (bus.done) begin dones++; done_at = k; end
    end
    $display("held-start mul: dones=%0d done_at=%0d reinits=%0d acc=%0d", dones, done_at, inits, acc);
    n_checks++;
    if (dones !== 1 || done_at !== 10 || inits !== 0) begin
      n_fail++; $display("FAIL held_start got dones %0d at %0d reinits %0d exp 1/10/0", dones, done_at, inits);
    end
    n_checks++;
    if (acc !== 8'd143) begin n_fail++; $display("FAIL held_acc got %0d exp 143", acc); end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL held_idle_busy got %0d exp 0", bus.busy); end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.acc_init !== 1'b1) begin
      n_fail++; $display("FAIL held_reaccept got busy %0d init %0d exp 1/1", bus.busy, bus.acc_init);
    end
    bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!fin) begin
        @(negedge clk);
        if (bus.done) fin = 1'b1;
      end
    end
    n_checks++;
    if (fin !== 1'b1) begin n_fail++; $display("FAIL held_second_done got %0d exp 1", fin); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    dp_a = {4'd0, 4'd7}; dp_b = 4'd9; bus.opcode = 3'd3; bus.b_zero = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midmul_busy got %0d exp 1", bus.busy); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== 14'd0) begin n_fail++; $display("FAIL midreset_outs got %b exp 0", outs); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    $display("reset mid-mul: activity cycles after release=%0d", dones);
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midreset_abort got %0d active cycles exp 0", dones); end
  endtask

`ifdef ALU_SEQ_PERF_EN
  task automatic test_perf();
    int lat, sc; logic e, dv, ee;
    run_op(3'd0, 8'd18, 4'd2, 1'b0, lat, e, sc, dv, ee);
    n_checks++;
    if (bus.perf_cycles !== 8'd3) begin n_fail++; $display("FAIL perf_add got %0d exp 3", bus.perf_cycles); end
    run_op(3'd3, 8'd6, 4'd7, 1'b0, lat, e, sc, dv, ee);
    n_checks++;
    if (bus.perf_cycles !== 8'd10) begin n_fail++; $display("FAIL perf_mul got %0d exp 10", bus.perf_cycles); end
    n_checks++;
    if (bus.op_count !== 8'd2) begin n_fail++; $display("FAIL op_count got %0d exp 2", bus.op_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_fixed();
    test_alu_random();
    test_mul();
    test_div();
    test_errors();
    test_start_held();
    test_reset_mid();
`ifdef ALU_SEQ_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
